// File: rtl/axil_mem_slave.sv
// AXI4-Lite slave word memory; optional out-of-range SLVERR via AXIL_MEM_RANGE_CHECK_EN.
// Latency: BVALID/RVALID one cycle after the completing AW+W / AR handshake; all outputs registered.
// Backpressure: one outstanding op per direction, READYs low until the B/R response is accepted.
module axil_mem_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [1:0]            BRESP,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [1:0]            RRESP,
  output logic [DATA_WIDTH-1:0] RDATA
);

  localparam int B      = $clog2(DATA_WIDTH / 8);
  localparam int IDX_HI = DEPTH_LOG2 + B - 1;
  localparam int DEPTH  = 1 << DEPTH_LOG2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_COMMIT, WR_RESP} wr_state_t;
  typedef enum logic       {RD_IDLE, RD_RESP}            rd_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic aw_oor;
  logic ar_oor;
  logic unused_addr_bits;

`ifdef AXIL_MEM_RANGE_CHECK_EN
  assign aw_oor           = |AWADDR[ADDR_WIDTH-1:IDX_HI+1];
  assign ar_oor           = |ARADDR[ADDR_WIDTH-1:IDX_HI+1];
  assign unused_addr_bits = ^{AWADDR[B-1:0], ARADDR[B-1:0]};
`else
  assign aw_oor           = 1'b0;
  assign ar_oor           = 1'b0;
  assign unused_addr_bits = ^{AWADDR[B-1:0], ARADDR[B-1:0],
                              AWADDR[ADDR_WIDTH-1:IDX_HI+1], ARADDR[ADDR_WIDTH-1:IDX_HI+1]};
`endif

  // ---------------- write path ----------------
  wr_state_t wr_state, wr_state_nxt;
  logic      aw_held, aw_held_nxt;
  logic      w_held, w_held_nxt;
  logic      wr_commit;
  logic [DEPTH_LOG2-1:0] aw_idx_q;
  logic                  aw_oor_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  aw_hs, w_hs;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  wr_oor;
  logic [DATA_WIDTH-1:0] wr_data;

  assign aw_hs   = AWVALID & AWREADY;
  assign w_hs    = WVALID & WREADY;
  assign wr_idx  = aw_held ? aw_idx_q : AWADDR[IDX_HI:B];
  assign wr_oor  = aw_held ? aw_oor_q : aw_oor;
  assign wr_data = w_held  ? wdata_q  : WDATA;

  // The commit happens on the completing handshake edge, so IDLE steps straight to RESP;
  // WR_COMMIT only acts as a safe pass-through should it ever be reached.
  always_comb begin
    wr_state_nxt = wr_state;
    aw_held_nxt  = aw_held;
    w_held_nxt   = w_held;
    wr_commit    = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs) aw_held_nxt = 1'b1;
        if (w_hs)  w_held_nxt  = 1'b1;
        if ((aw_held | aw_hs) && (w_held | w_hs)) begin
          wr_commit    = 1'b1;
          aw_held_nxt  = 1'b0;
          w_held_nxt   = 1'b0;
          wr_state_nxt = WR_RESP;
        end
      end
      WR_COMMIT: wr_state_nxt = WR_RESP;
      WR_RESP:   if (BREADY) wr_state_nxt = WR_IDLE;
      default:   wr_state_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_state <= WR_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      BVALID   <= 1'b0;
      BRESP    <= RESP_OKAY;
      aw_idx_q <= '0;
      aw_oor_q <= 1'b0;
      wdata_q  <= '0;
    end else begin
      wr_state <= wr_state_nxt;
      aw_held  <= aw_held_nxt;
      w_held   <= w_held_nxt;
      AWREADY  <= (wr_state_nxt == WR_IDLE) && !aw_held_nxt;
      WREADY   <= (wr_state_nxt == WR_IDLE) && !w_held_nxt;
      BVALID   <= (wr_state_nxt == WR_RESP);
      if (aw_hs) begin
        aw_idx_q <= AWADDR[IDX_HI:B];
        aw_oor_q <= aw_oor;
      end
      if (w_hs) wdata_q <= WDATA;
      if (wr_commit) BRESP <= wr_oor ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Array is not reset; a commit coinciding with reset is dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_commit && !wr_oor) mem[wr_idx] <= wr_data;
  end

  // ---------------- read path ----------------
  rd_state_t rd_state, rd_state_nxt;
  logic      ar_hs;

  assign ar_hs = ARVALID & ARREADY;

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs)  rd_state_nxt = RD_RESP;
      RD_RESP: if (RREADY) rd_state_nxt = RD_IDLE;
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  // Reading mem here sees the pre-write value on a same-edge collision.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_state <= RD_IDLE;
      ARREADY  <= 1'b0;
      RVALID   <= 1'b0;
      RRESP    <= RESP_OKAY;
      RDATA    <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      ARREADY  <= (rd_state_nxt == RD_IDLE);
      RVALID   <= (rd_state_nxt == RD_RESP);
      if (ar_hs) begin
        RDATA <= ar_oor ? '0 : mem[ARADDR[IDX_HI:B]];
        RRESP <= ar_oor ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axil_mem_slave.sv
// Bench for axil_mem_slave: directed table, hand-written corner sequences, randomized traffic vs a word-array model.
module tb_axil_mem_slave;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DL = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          AWVALID, AWREADY;
  logic [AW-1:0] AWADDR;
  logic          WVALID, WREADY;
  logic [DW-1:0] WDATA;
  logic          BVALID, BREADY;
  logic [1:0]    BRESP;
  logic          ARVALID, ARREADY;
  logic [AW-1:0] ARADDR;
  logic          RVALID, RREADY;
  logic [1:0]    RRESP;
  logic [DW-1:0] RDATA;

  always #5 i_clk = ~i_clk;

  axil_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RRESP(RRESP), .RDATA(RDATA)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model_mem [256];
  bit          model_vld [256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic bit is_oor(input logic [31:0] a);
`ifdef AXIL_MEM_RANGE_CHECK_EN
    return a >= 32'd1024;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % 256);
  endfunction

  function automatic void model_wr(input logic [31:0] a, input logic [31:0] d);
    if (!is_oor(a)) begin
      model_mem[word_of(a)] = d;
      model_vld[word_of(a)] = 1'b1;
    end
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp);
    bit aw_done, w_done, aw_now, w_now;
    int c, guard;
    aw_done = 1'b0; w_done = 1'b0; c = 0;
    while (!(aw_done && w_done) && c < 60) begin
      AWADDR  = addr;
      WDATA   = data;
      AWVALID = !aw_done && (c >= aw_dly);
      WVALID  = !w_done && (c >= w_dly);
      aw_now  = AWVALID && AWREADY;
      w_now   = WVALID && WREADY;
      tick();
      c++;
      if (aw_now) aw_done = 1'b1;
      if (w_now)  w_done  = 1'b1;
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      if (w_done && !aw_done) check("wready_after_w", WREADY, 0);
      if (aw_done && !w_done) check("awready_after_aw", AWREADY, 0);
    end
    check("write_handshakes", {aw_done, w_done}, 2'b11);
    check("b_latency", BVALID, 1);
    guard = 0;
    while (!BVALID && guard < 20) begin tick(); guard++; end
    resp = BRESP;
    repeat (b_dly) begin
      tick();
      check("b_hold", {BVALID, BRESP}, {1'b1, resp});
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("b_drop_ready_back", {BVALID, AWREADY, WREADY}, 3'b011);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    bit done, now;
    int c, guard;
    done = 1'b0; c = 0;
    while (!done && c < 60) begin
      ARVALID = 1'b1;
      ARADDR  = addr;
      now     = ARREADY;
      tick();
      c++;
      if (now) done = 1'b1;
    end
    ARVALID = 1'b0;
    check("ar_handshake", done, 1);
    check("r_latency", RVALID, 1);
    guard = 0;
    while (!RVALID && guard < 20) begin tick(); guard++; end
    data = RDATA;
    resp = RRESP;
    repeat (r_dly) begin
      tick();
      check("r_hold", {RVALID, RRESP, RDATA}, {1'b1, resp, data});
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check("r_drop_ready_back", {RVALID, ARREADY}, 2'b01);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input int awd, input int wd, input int bd);
    logic [1:0] r;
    axi_write(a, d, awd, wd, bd, r);
    check("model_bresp", r, is_oor(a) ? 2'b10 : 2'b00);
    model_wr(a, d);
  endtask

  task automatic do_read(input logic [31:0] a, input int rd);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, rd, d, r);
    if (is_oor(a)) begin
      check("model_oor_rresp", r, 2'b10);
      check("model_oor_rdata", d, 0);
    end else begin
      check("model_rresp", r, 2'b00);
      if (model_vld[word_of(a)]) check("model_rdata", d, model_mem[word_of(a)]);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    bit          seen;

    tbl[0] = '{1'b1, 32'h0000_0040, 32'hA5A5_0001, 2'b00};
    tbl[1] = '{1'b1, 32'h0000_0044, 32'h5A5A_0002, 2'b00};
    tbl[2] = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 2'b00};
    tbl[3] = '{1'b0, 32'h0000_0040, 32'hA5A5_0001, 2'b00};
    tbl[4] = '{1'b0, 32'h0000_03FE, 32'hCAFE_F00D, 2'b00};
    tbl[5] = '{1'b1, 32'h0000_0041, 32'h0BAD_BEEF, 2'b00};
    tbl[6] = '{1'b0, 32'h0000_0040, 32'h0BAD_BEEF, 2'b00};
    tbl[7] = '{1'b0, 32'h0000_0044, 32'h5A5A_0002, 2'b00};

    for (int i = 0; i < 256; i++) model_vld[i] = 1'b0;

    i_rst = 1'b1;
    AWVALID = 0; AWADDR = 0; WVALID = 0; WDATA = 0; BREADY = 0;
    ARVALID = 0; ARADDR = 0; RREADY = 0;

    // Reset: everything low while held, READYs high right after release.
    repeat (3) tick();
    check("rst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
    check("rst_valid", {BVALID, RVALID}, 2'b00);
    check("rst_resp", {BRESP, RRESP}, 4'b0000);
    check("rst_rdata", RDATA, 0);
    i_rst = 1'b0;
    tick();
    check("release_ready", {AWREADY, WREADY, ARREADY}, 3'b111);

    // AW and W in the same cycle, then read back.
    axi_write(32'h10, 32'hDEAD_BEEF, 0, 0, 0, r);
    check("same_cycle_bresp", r, 2'b00);
    model_wr(32'h10, 32'hDEAD_BEEF);
    axi_read(32'h10, 0, d, r);
    check("same_cycle_rdata", d, 32'hDEAD_BEEF);
    check("same_cycle_rresp", r, 2'b00);

    // W three cycles ahead of AW, BREADY withheld four cycles.
    axi_write(32'h20, 32'h1234_5678, 3, 0, 4, r);
    check("ooo_bresp", r, 2'b00);
    model_wr(32'h20, 32'h1234_5678);
    axi_read(32'h20, 2, d, r);
    check("ooo_rdata", d, 32'h1234_5678);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, i % 3, (i + 1) % 3, i % 2, r);
        check("tbl_bresp", r, tbl[i].exp_resp);
        model_wr(tbl[i].addr, tbl[i].data);
      end else begin
        axi_read(tbl[i].addr, i % 3, d, r);
        check("tbl_rresp", r, tbl[i].exp_resp);
        check("tbl_rdata", d, tbl[i].data);
      end
    end

    // Collision: write commit and AR handshake on the same edge.
    axi_write(32'h30, 32'h1, 0, 0, 0, r);
    model_wr(32'h30, 32'h1);
    check("coll_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
    AWVALID = 1; AWADDR = 32'h30; WVALID = 1; WDATA = 32'h2;
    ARVALID = 1; ARADDR = 32'h30;
    tick();
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    check("coll_valids", {BVALID, RVALID}, 2'b11);
    check("coll_old_data", RDATA, 32'h1);
    BREADY = 1; RREADY = 1;
    tick();
    BREADY = 0; RREADY = 0;
    check("coll_drop", {BVALID, RVALID}, 2'b00);
    model_wr(32'h30, 32'h2);
    axi_read(32'h30, 0, d, r);
    check("coll_new_data", d, 32'h2);

    // Range check / aliasing at 0x400.
    axi_write(32'h0, 32'h55, 0, 0, 0, r);
    model_wr(32'h0, 32'h55);
    axi_write(32'h400, 32'hAAAA, 0, 0, 0, r);
`ifdef AXIL_MEM_RANGE_CHECK_EN
    check("range_bresp", r, 2'b10);
    axi_read(32'h400, 0, d, r);
    check("range_rresp", r, 2'b10);
    check("range_rdata", d, 0);
    axi_read(32'h0, 0, d, r);
    check("range_word0_kept", d, 32'h55);
`else
    check("alias_bresp", r, 2'b00);
    axi_read(32'h0, 0, d, r);
    check("alias_rdata", d, 32'hAAAA);
    check("alias_rresp", r, 2'b00);
`endif
    model_wr(32'h400, 32'hAAAA);

    // Reset while BVALID pending.
    AWVALID = 1; AWADDR = 32'h50; WVALID = 1; WDATA = 32'h77;
    tick();
    AWVALID = 0; WVALID = 0;
    check("midrst_bvalid_before", BVALID, 1);
    model_wr(32'h50, 32'h77);
    i_rst = 1'b1;
    tick();
    check("midrst_bvalid", BVALID, 0);
    check("midrst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
    i_rst = 1'b0;
    BREADY = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (BVALID) seen = 1'b1;
    end
    BREADY = 1'b0;
    check("midrst_no_b", seen, 0);
    axi_read(32'h10, 0, d, r);
    check("midrst_data_kept", d, 32'hDEAD_BEEF);
    do_read(32'h50, 1);

    // Randomized traffic against the model; low address bits are don't-care.
    for (int i = 0; i < 200; i++) begin
      int          idx;
      logic [31:0] a;
      idx = int'($urandom_range(0, 255));
      a   = (idx * 4) | $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)));
      else
        do_read(a, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
